ps2_event_ctrl: RTL and testbench

- Sequences the raw PS/2 byte stream from ps2_keyboard into complete key events (code, extended, make/break).
- Parses the E0, F0 and E1 prefixes, suppresses typematic repeats of held keys and services the byte FIFO's overflow flag.
- Sits between ps2_keyboard (out_valid/out_ready, overflow/of_clear) and downstream consumers.

---
 rtl/ps2_event_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_ps2_event_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_event_ctrl.sv
// ps2_event_ctrl
// Turns the raw PS/2 scan-code byte stream into complete key events.
// It handles the E0 and F0 prefixes, the E1 pause sequence, the held-key
// repeat filter and the keyboard FIFO overflow flag.
//
// Ports:
//   clk         system clock
//   clrn        asynchronous reset, active-high
//   in_data     byte at the keyboard FIFO head
//   in_valid    in_data is valid
//   in_ready    byte is consumed on this edge when in_valid is also high
//   in_of       keyboard FIFO overflow flag
//   of_clear    clears the keyboard overflow flag (in_of delayed one cycle)
//   ev_code     event scan code
//   ev_ext      event carried an E0 prefix
//   ev_break    event is a key release
//   ev_valid    event valid
//   ev_ready    consumer accepts the event
//   held_count  occupied entries in the held-key table
//   ovf_count   overflow episodes, saturating at 255
//   err_count   keyboard error bytes (0x00/0xFF), saturating at 255
module ps2_event_ctrl #(
    parameter int HELD_DEPTH    = 4,
    parameter bit FILTER_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_of,
    output logic       of_clear,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [3:0] held_count,
    output logic [7:0] ovf_count,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_E1SKIP, S_OUT} state_t;

    state_t state_reg;
    state_t parse_next;
    logic [2:0] skip_reg;
    logic [2:0] skip_next;

    logic       held_valid_reg [HELD_DEPTH];
    logic [8:0] held_key_reg   [HELD_DEPTH];
    logic [HELD_DEPTH-1:0] held_valid;
    logic [HELD_DEPTH-1:0] hit_vec;
    logic [HELD_DEPTH-1:0] ins_onehot;
    logic [HELD_DEPTH-1:0] tbl_set;
    logic [HELD_DEPTH-1:0] tbl_clear;
    logic       hit_any;

    logic       dec_emit;
    logic       dec_track;
    logic       dec_err;
    logic       dec_ext;
    logic       dec_break;
    logic [7:0] dec_code;
    logic [8:0] dec_key;
    logic       dec_drop;

    logic       of_rise;
    logic       take;
    logic       tbl_upd;

    assign in_ready = (state_reg != S_OUT);
    // of_clear doubles as the previous sample of in_of for edge detection.
    assign of_rise  = in_of & ~of_clear;
    // A byte arriving on the overflow edge is consumed but ignored.
    assign take     = in_valid & in_ready & ~of_rise;

    // Byte decode for the current parse state.
    always_comb begin
        parse_next = state_reg;
        skip_next  = skip_reg;
        dec_emit   = 1'b0;
        dec_track  = 1'b0;
        dec_err    = 1'b0;
        dec_ext    = 1'b0;
        dec_break  = 1'b0;
        dec_code   = in_data;
        case (state_reg)
            S_IDLE: begin
                case (in_data)
                    8'hE0: parse_next = S_E0;
                    8'hF0: parse_next = S_F0;
                    8'hE1: begin
                        parse_next = S_E1SKIP;
                        skip_next  = 3'd7;
                    end
                    8'hAA, 8'hFA, 8'hFE, 8'hEE: ;
                    8'h00, 8'hFF: dec_err = 1'b1;
                    default: begin
                        dec_emit  = 1'b1;
                        dec_track = 1'b1;
                    end
                endcase
            end
            S_E0: begin
                if (in_data == 8'hF0) begin
                    parse_next = S_E0F0;
                end else if (in_data == 8'h12) begin
                    parse_next = S_IDLE;   // fake shift
                end else begin
                    dec_emit  = 1'b1;
                    dec_track = 1'b1;
                    dec_ext   = 1'b1;
                end
            end
            S_F0: begin
                dec_emit  = 1'b1;
                dec_track = 1'b1;
                dec_break = 1'b1;
            end
            S_E0F0: begin
                if (in_data == 8'h12) begin
                    parse_next = S_IDLE;
                end else begin
                    dec_emit  = 1'b1;
                    dec_track = 1'b1;
                    dec_ext   = 1'b1;
                    dec_break = 1'b1;
                end
            end
            S_E1SKIP: begin
                skip_next = skip_reg - 3'd1;
                // Pause is reported once, on the last byte of the sequence.
                if (skip_reg == 3'd1) begin
                    dec_emit = 1'b1;
                    dec_code = 8'hE1;
                end
            end
            default: ;
        endcase
    end

    assign dec_key  = {dec_ext, dec_code};
    assign hit_any  = |hit_vec;
    assign dec_drop = dec_emit & dec_track & ~dec_break & FILTER_REPEAT & hit_any;
    assign tbl_upd  = take & dec_emit & dec_track & ~dec_drop;
    assign tbl_clear = {HELD_DEPTH{tbl_upd & dec_break}} & hit_vec;
    // Keys that do not fit in a full table are emitted but not recorded.
    assign tbl_set   = {HELD_DEPTH{tbl_upd & ~dec_break & ~hit_any}} & ins_onehot;

    // Lowest free entry, one-hot.
    always_comb begin
        logic found;
        found      = 1'b0;
        ins_onehot = '0;
        for (int i = 0; i < HELD_DEPTH; i++) begin
            if (!held_valid[i] && !found) begin
                ins_onehot[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    always_comb begin
        held_count = 4'd0;
        for (int i = 0; i < HELD_DEPTH; i++) begin
            held_count = held_count + 4'(held_valid[i]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < HELD_DEPTH; gi++) begin : g_held
            assign held_valid[gi] = held_valid_reg[gi];
            assign hit_vec[gi]    = held_valid_reg[gi] && (held_key_reg[gi] == dec_key);

            always_ff @(posedge clk or posedge clrn) begin
                if (clrn) begin
                    held_valid_reg[gi] <= 1'b0;
                    held_key_reg[gi]   <= 9'd0;
                end else if (of_rise || tbl_clear[gi]) begin
                    held_valid_reg[gi] <= 1'b0;
                end else if (tbl_set[gi]) begin
                    held_valid_reg[gi] <= 1'b1;
                    held_key_reg[gi]   <= dec_key;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_reg <= S_IDLE;
            skip_reg  <= 3'd0;
            of_clear  <= 1'b0;
            ev_code   <= 8'd0;
            ev_ext    <= 1'b0;
            ev_break  <= 1'b0;
            ev_valid  <= 1'b0;
            ovf_count <= 8'd0;
            err_count <= 8'd0;
        end else begin
            of_clear <= in_of;
            if (state_reg == S_OUT) begin
                // A pending event survives an overflow episode.
                if (ev_ready) begin
                    ev_valid  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            end else if (of_rise) begin
                state_reg <= S_IDLE;
                skip_reg  <= 3'd0;
            end else if (take) begin
                skip_reg <= skip_next;
                if (dec_err && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                if (dec_emit && !dec_drop) begin
                    ev_code   <= dec_code;
                    ev_ext    <= dec_ext;
                    ev_break  <= dec_break;
                    ev_valid  <= 1'b1;
                    state_reg <= S_OUT;
                end else if (dec_emit) begin
                    state_reg <= S_IDLE;
                end else begin
                    state_reg <= parse_next;
                end
            end
            if (of_rise && ovf_count != 8'hFF) begin
                ovf_count <= ovf_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_event_ctrl.sv
module tb_ps2_event_ctrl;

    logic       clk = 1'b0;
    logic       clrn = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_of = 1'b0;
    logic       of_clear;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_valid;
    logic       ev_ready = 1'b1;
    logic [3:0] held_count;
    logic [7:0] ovf_count;
    logic [7:0] err_count;

    // Second instance with the repeat filter disabled.
    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic       in_of1 = 1'b0;
    logic       of_clear1;
    logic [7:0] ev_code1;
    logic       ev_ext1;
    logic       ev_break1;
    logic       ev_valid1;
    logic       ev_ready1 = 1'b1;
    logic [3:0] held_count1;
    logic [7:0] ovf_count1;
    logic [7:0] err_count1;

    int checks = 0;
    int passed = 0;
    int ev1_cnt = 0;
    logic [9:0] evq[$];   // {ext, break, code}

    always #5 clk = ~clk;

    ps2_event_ctrl #(.HELD_DEPTH(4), .FILTER_REPEAT(1'b1)) dut (
        .clk(clk), .clrn(clrn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_of(in_of), .of_clear(of_clear),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .held_count(held_count),
        .ovf_count(ovf_count), .err_count(err_count)
    );

    ps2_event_ctrl #(.HELD_DEPTH(4), .FILTER_REPEAT(1'b0)) dut1 (
        .clk(clk), .clrn(clrn), .in_data(in_data), .in_valid(in_valid1),
        .in_ready(in_ready1), .in_of(in_of1), .of_clear(of_clear1),
        .ev_code(ev_code1), .ev_ext(ev_ext1), .ev_break(ev_break1),
        .ev_valid(ev_valid1), .ev_ready(ev_ready1), .held_count(held_count1),
        .ovf_count(ovf_count1), .err_count(err_count1)
    );

    // Record every completed event handshake.
    always @(posedge clk) begin
        if (!clrn && ev_valid && ev_ready) evq.push_back({ev_ext, ev_break, ev_code});
        if (!clrn && ev_valid1 && ev_ready1) ev1_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        int n;
        n = 0;
        in_data   = b;
        in_valid1 = 1'b1;
        while (!in_ready1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("send1_timeout", 32'(in_ready1), 32'd1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
    endtask

    initial begin
        logic ok;
        // Reset state
        cycles(2);
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_counts", {held_count, ovf_count, err_count}, 32'd0);
        check("rst_of_clear", 32'(of_clear), 32'd0);
        @(negedge clk); clrn = 1'b0;
        cycles(1);

        // Make then break
        send(8'h1C); cycles(3);
        check("mk_count", evq.size(), 32'd1);
        check("mk_event", 32'(evq[0]), 32'h01C);
        check("mk_held", 32'(held_count), 32'd1);
        send(8'hF0); send(8'h1C); cycles(3);
        check("brk_count", evq.size(), 32'd2);
        check("brk_event", 32'(evq[1]), 32'h11C);
        check("brk_held", 32'(held_count), 32'd0);

        // Extended key wrapped in fake shifts
        evq.delete();
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h75); cycles(3);
        check("ext_held", 32'(held_count), 32'd1);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h12); cycles(3);
        check("ext_count", evq.size(), 32'd2);
        check("ext_make", 32'(evq[0]), 32'h275);
        check("ext_break", 32'(evq[1]), 32'h375);

        // Repeat filter on, then off
        evq.delete();
        send(8'h1C); send(8'h1C); send(8'h1C); cycles(3);
        check("rep_on_count", evq.size(), 32'd1);
        check("rep_on_held", 32'(held_count), 32'd1);
        send(8'hF0); send(8'h1C); cycles(3);
        send1(8'h1C); send1(8'h1C); send1(8'h1C); cycles(3);
        check("rep_off_count", 32'(ev1_cnt), 32'd3);
        check("rep_off_held", 32'(held_count1), 32'd1);

        // Fill the table past capacity
        evq.delete();
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); cycles(3);
        check("fill_count", evq.size(), 32'd5);
        check("fill_held", 32'(held_count), 32'd4);
        send(8'h2C); cycles(3);   // unrecorded key is not filtered
        check("fill_unrec", evq.size(), 32'd6);

        // Backpressure
        ev_ready = 1'b0;
        send(8'h1B);
        in_data  = 8'h23;
        in_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            if (!(ev_valid === 1'b1 && ev_code === 8'h1B && ev_ext === 1'b0 &&
                  ev_break === 1'b0 && in_ready === 1'b0)) ok = 1'b0;
        end
        check("bp_stable", 32'(ok), 32'd1);
        ev_ready = 1'b1;
        cycles(1);
        check("bp_release", {31'd0, ev_valid}, 32'd0);
        check("bp_ready", 32'(in_ready), 32'd1);
        cycles(1);
        in_valid = 1'b0;
        check("bp_next", {23'd0, ev_valid, ev_code}, 32'h123);
        cycles(3);

        // Pause sequence
        evq.delete();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); cycles(3);
        check("pause_count", evq.size(), 32'd1);
        check("pause_event", 32'(evq[0]), 32'h0E1);
        check("pause_held", 32'(held_count), 32'd4);

        // Error bytes
        send(8'h00); send(8'hFF); cycles(1);
        check("err_count", 32'(err_count), 32'd2);

        // Overflow while a break prefix is pending
        evq.delete();
        send(8'hF0);
        in_of = 1'b1;
        check("of_lag", 32'(of_clear), 32'd0);
        cycles(1);
        check("of_clear_hi", 32'(of_clear), 32'd1);
        check("ovf_count", 32'(ovf_count), 32'd1);
        check("ovf_flush", 32'(held_count), 32'd0);
        cycles(2);
        check("ovf_once", 32'(ovf_count), 32'd1);
        in_of = 1'b0;
        cycles(1);
        check("of_clear_lo", 32'(of_clear), 32'd0);
        send(8'h1C); cycles(3);
        check("ovf_next", 32'(evq[0]), 32'h01C);
        check("ovf_nextn", evq.size(), 32'd1);

        // Asynchronous reset while an event is pending
        ev_ready = 1'b0;
        send(8'h2A);
        check("pre_rst_valid", 32'(ev_valid), 32'd1);
        #2 clrn = 1'b1;
        #1;
        check("arst_valid", 32'(ev_valid), 32'd0);
        check("arst_counts", {held_count, ovf_count, err_count}, 32'd0);
        @(negedge clk); clrn = 1'b0;
        ev_ready = 1'b1;
        evq.delete();
        cycles(1);
        send(8'h1C); cycles(3);
        check("post_rst_cnt", evq.size(), 32'd1);
        check("post_rst_ev", 32'(evq[0]), 32'h01C);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
